// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch stepping on rising edges of tick_clk, all in the CCLK domain.
// Define LAP_STOPWATCH_EN to build the lap-capture ports and logic.
module bcd_stopwatch #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                CCLK,
  input  logic                reset,
  input  logic                tick_clk,
  input  logic                btn_start,
  input  logic                btn_stop,
  input  logic                btn_clear,
  input  logic                up_down,
`ifdef LAP_STOPWATCH_EN
  input  logic                btn_lap,
  output logic [4*DIGITS-1:0] lap_digits,
  output logic                lap_valid,
`endif
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                wrapped
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e              state;
  logic                tick_q;
  logic                tick_rise;
  logic                step;
  logic                sub_last;
  logic [7:0]          sub;
  logic [4*DIGITS-1:0] digits_nxt;
  logic                carry;
  logic [3:0]          dig;

  assign tick_rise = tick_clk & ~tick_q;
  // A rise arriving with stop/clear, or before RUN is entered, is dropped.
  assign step      = (state == StRun) & tick_rise & ~btn_stop & ~btn_clear;
  assign sub_last  = (sub == 8'(TICK_DIV - 1));

  // Ripple carry/borrow across digits; carry out of the top digit marks a wrap.
  always_comb begin
    digits_nxt = digits;
    carry      = 1'b1;
    dig        = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = digits[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          carry                = (dig == 4'd9);
          digits_nxt[4*i +: 4] = carry ? 4'd0 : dig + 4'd1;
        end else begin
          carry                = (dig == 4'd0);
          digits_nxt[4*i +: 4] = carry ? 4'd9 : dig - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CCLK) begin
    tick_q <= tick_clk;
    if (reset) begin
      state   <= StIdle;
      digits  <= '0;
      sub     <= '0;
      running <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (btn_clear) begin
        state   <= StIdle;
        digits  <= '0;
        sub     <= '0;
        running <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StPause: begin
            if (btn_start) begin
              state   <= StRun;
              running <= 1'b1;
            end
          end
          StRun: begin
            if (btn_stop) begin
              state   <= StPause;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= StIdle;
            running <= 1'b0;
          end
        endcase
        if (step) begin
          if (sub_last) begin
            sub     <= '0;
            digits  <= digits_nxt;
            wrapped <= carry;
          end else begin
            sub <= sub + 8'd1;
          end
        end
      end
    end
  end

`ifdef LAP_STOPWATCH_EN
  // Captures the value shown before any step taken in the same cycle.
  always_ff @(posedge CCLK) begin
    if (reset || btn_clear) begin
      lap_digits <= '0;
      lap_valid  <= 1'b0;
    end else if (btn_lap && state == StRun) begin
      lap_digits <= digits;
      lap_valid  <= 1'b1;
    end
  end
`endif

endmodule
